wb_stage: RTL

Writeback stage of the PikaRISC pipeline, directly downstream of the memory stage. Holds the MEM/WB pipeline register and selects the writeback value: load data from data memory, or the ALU result passed through. Drives the register-file write port, which doubles as the forwarding source for earlier stages. Keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   Writeback stage of the PikaRISC pipeline. Holds the MEM/WB pipeline
//   register, selects the writeback value (load data or ALU result) and drives
//   the register-file write port, which also serves as the forwarding source
//   for earlier stages. Counts retired instructions.
//
// Ports
//   clk                   : single clock, rising edge
//   reset                 : synchronous, active-high; clears all state
//   stall                 : hold MEM/WB register contents
//   flush                 : load a bubble into the MEM/WB register
//   valid_in              : memory stage holds a real instruction
//   is_ld_op_passthrough  : instruction is a load
//   is_wb_op_passthrough  : instruction writes a destination register
//   rd_passthrough        : destination register index
//   rd_val_passthrough    : ALU result from memory stage
//   dmem_val_passthrough  : load data from memory stage
//   rf_write_en           : register-file write enable / forward valid
//   rf_write_addr         : register-file write index
//   rf_write_val          : register-file write data
//   retired_count         : retired-instruction count (wraps)
//
// Handshake: there is no valid/ready pair here. valid_in qualifies the
// incoming instruction; the stage accepts it on every edge where reset,
// flush and stall are all low. stall holds the register, flush replaces it
// with a bubble. Priority on an edge: reset > flush > stall > capture.
// -----------------------------------------------------------------------------
module wb_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = 32,
   parameter bit ZERO_REG_WIRED = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      valid_in,
   input  logic                      is_ld_op_passthrough,
   input  logic                      is_wb_op_passthrough,
   input  logic [REG_ADDR_WIDTH-1:0] rd_passthrough,
   input  logic [DATA_WIDTH-1:0]     rd_val_passthrough,
   input  logic [DATA_WIDTH-1:0]     dmem_val_passthrough,
   output logic                      rf_write_en,
   output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
   output logic [DATA_WIDTH-1:0]     rf_write_val,
   output logic [COUNT_WIDTH-1:0]    retired_count
);

   // MEM/WB pipeline register
   logic                      valid_q;
   logic                      ld_q;
   logic                      wb_q;
   logic [REG_ADDR_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0]     alu_q;
   logic [DATA_WIDTH-1:0]     dmem_q;

   // The held instruction leaves the register (and so retires) whenever the
   // register is overwritten: by a flush, or by a normal unstalled capture.
   logic retire;
   assign retire = valid_q & (flush | ~stall);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q       <= 1'b0;
         ld_q          <= 1'b0;
         wb_q          <= 1'b0;
         rd_q          <= '0;
         alu_q         <= '0;
         dmem_q        <= '0;
         retired_count <= '0;
      end else begin
         if (flush) begin
            // Only valid_q matters for a bubble; other fields keep their
            // values, which is harmless because rf_write_en is gated by valid_q.
            valid_q <= 1'b0;
         end else if (!stall) begin
            valid_q <= valid_in;
            ld_q    <= is_ld_op_passthrough;
            wb_q    <= is_wb_op_passthrough;
            rd_q    <= rd_passthrough;
            alu_q   <= rd_val_passthrough;
            dmem_q  <= dmem_val_passthrough;
         end
         if (retire) begin
            retired_count <= retired_count + 1'b1;  // wraps naturally
         end
      end
   end

   logic zero_dest;
   assign zero_dest = ZERO_REG_WIRED && (rd_q == '0);

   assign rf_write_en   = valid_q & wb_q & ~zero_dest;
   assign rf_write_addr = rd_q;
   assign rf_write_val  = ld_q ? dmem_q : alu_q;

endmodule
